// File: rtl/pq_pkg.sv
// Shared opcodes, FSM state type and command-word packing for the priority-queue host driver.
package pq_pkg;

    localparam int W_DEFAULT     = 65;
    localparam int DEPTH_DEFAULT = 1000;

    // Upper bound on the value width the packing helper can handle.
    localparam int VAL_MAX_W = 126;
    localparam int CMD_MAX_W = VAL_MAX_W + 2;

    localparam logic [1:0] OP_PUSH = 2'b00;
    localparam logic [1:0] OP_POP  = 2'b01;
    localparam logic [1:0] OP_NOP  = 2'b10;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ISSUE,
        ST_WAIT,
        ST_RESP
    } state_t;

    // Places op at bits [w+1:w] above a w-bit value; callers truncate to w+2 bits.
    function automatic logic [CMD_MAX_W-1:0] pack_cmd(input logic [1:0]           op,
                                                       input logic [VAL_MAX_W-1:0] val,
                                                       input int unsigned          w);
        logic [CMD_MAX_W-1:0] mask;
        mask = (CMD_MAX_W'(1) << w) - CMD_MAX_W'(1);
        return (CMD_MAX_W'(val) & mask) | (CMD_MAX_W'(op) << w);
    endfunction

endpackage

// File: rtl/pq_host_driver_if.sv
// Client request/response handshakes plus the queue command/status wires of the host driver.
interface pq_host_driver_if
    import pq_pkg::*;
#(
    parameter int W     = W_DEFAULT,
    parameter int DEPTH = DEPTH_DEFAULT
);
    localparam int CW = $clog2(DEPTH + 1);

    logic          req_valid_i;
    logic          req_ready_o;
    logic          req_op_i;
    logic [W-1:0]  req_data_i;
    logic [W+1:0]  cmd_o;
    logic          pq_busy_i;
    logic [W-1:0]  pq_top_i;
    logic          rsp_valid_o;
    logic          rsp_ready_i;
    logic [W-1:0]  rsp_data_o;
    logic          rsp_err_o;
    logic [CW-1:0] count_o;
    logic          fault_o;

    modport slave (
        input  req_valid_i, req_op_i, req_data_i, pq_busy_i, pq_top_i, rsp_ready_i,
        output req_ready_o, cmd_o, rsp_valid_o, rsp_data_o, rsp_err_o, count_o, fault_o
    );

    modport master (
        output req_valid_i, req_op_i, req_data_i, pq_busy_i, pq_top_i, rsp_ready_i,
        input  req_ready_o, cmd_o, rsp_valid_o, rsp_data_o, rsp_err_o, count_o, fault_o
    );

endinterface

// File: rtl/pq_watchdog.sv
// WAIT-cycle counter: counts enabled cycles and pulses expire on the TIMEOUT-th one.
module pq_watchdog #(
    parameter int TIMEOUT = 4096
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clear,
    input  logic enable,
    output logic expire
);
    localparam int CNT_W = $clog2(TIMEOUT + 1);

    logic [CNT_W-1:0] count_reg;

    assign expire = enable && (count_reg == CNT_W'(TIMEOUT - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_reg <= '0;
        end else if (clear) begin
            count_reg <= '0;
        end else if (enable) begin
            count_reg <= count_reg + CNT_W'(1);
        end
    end

endmodule

// File: rtl/pq_host_driver.sv
// Host-side driver for the heap priority queue: one request in flight, one response per request,
// occupancy tracking and a sticky watchdog fault when the queue never finishes.
module pq_host_driver
    import pq_pkg::*;
#(
    parameter int W       = W_DEFAULT,
    parameter int DEPTH   = DEPTH_DEFAULT,
    parameter int TIMEOUT = 4096
) (
    input  logic system1000,
    input  logic system1000_rstn,
    pq_host_driver_if.slave bus
);
    localparam int            CW       = $clog2(DEPTH + 1);
    localparam logic [CW-1:0] FULL     = CW'(DEPTH);
    localparam logic [W+1:0]  NOP_WORD = {OP_NOP, {W{1'b0}}};

    state_t        state_reg;
    logic [W+1:0]  cmd_reg;
    logic          rsp_valid_reg;
    logic [W-1:0]  rsp_data_reg;
    logic          rsp_err_reg;
    logic [CW-1:0] count_reg;
    logic          fault_reg;

    logic req_ready;
    logic accept;
    logic wd_clear;
    logic wd_enable;
    logic wd_expire;

    assign req_ready = (state_reg == ST_IDLE) && !bus.pq_busy_i;
    assign accept    = bus.req_valid_i && req_ready;
    assign wd_clear  = (state_reg != ST_WAIT);
    assign wd_enable = (state_reg == ST_WAIT) && bus.pq_busy_i;

    assign bus.req_ready_o = req_ready;
    assign bus.cmd_o       = cmd_reg;
    assign bus.rsp_valid_o = rsp_valid_reg;
    assign bus.rsp_data_o  = rsp_data_reg;
    assign bus.rsp_err_o   = rsp_err_reg;
    assign bus.count_o     = count_reg;
    assign bus.fault_o     = fault_reg;

    pq_watchdog #(
        .TIMEOUT(TIMEOUT)
    ) u_watchdog (
        .clk   (system1000),
        .rst_n (system1000_rstn),
        .clear (wd_clear),
        .enable(wd_enable),
        .expire(wd_expire)
    );

    always_ff @(posedge system1000 or negedge system1000_rstn) begin
        if (!system1000_rstn) begin
            state_reg     <= ST_IDLE;
            cmd_reg       <= NOP_WORD;
            rsp_valid_reg <= 1'b0;
            rsp_data_reg  <= '0;
            rsp_err_reg   <= 1'b0;
            count_reg     <= '0;
            fault_reg     <= 1'b0;
        end else begin
            case (state_reg)
                ST_IDLE: begin
                    if (accept) begin
                        if (!bus.req_op_i) begin
                            if (count_reg == FULL) begin
                                rsp_data_reg  <= '0;
                                rsp_err_reg   <= 1'b1;
                                rsp_valid_reg <= 1'b1;
                                state_reg     <= ST_RESP;
                            end else begin
                                cmd_reg      <= (W+2)'(pack_cmd(OP_PUSH, VAL_MAX_W'(bus.req_data_i), W));
                                count_reg    <= count_reg + CW'(1);
                                rsp_data_reg <= '0;
                                rsp_err_reg  <= 1'b0;
                                state_reg    <= ST_ISSUE;
                            end
                        end else begin
                            if (count_reg == '0) begin
                                rsp_data_reg  <= '0;
                                rsp_err_reg   <= 1'b1;
                                rsp_valid_reg <= 1'b1;
                                state_reg     <= ST_RESP;
                            end else begin
                                // The root is only trustworthy while the queue is idle, so grab it now.
                                cmd_reg      <= (W+2)'(pack_cmd(OP_POP, '0, W));
                                count_reg    <= count_reg - CW'(1);
                                rsp_data_reg <= bus.pq_top_i;
                                rsp_err_reg  <= 1'b0;
                                state_reg    <= ST_ISSUE;
                            end
                        end
                    end
                end
                ST_ISSUE: begin
                    cmd_reg   <= NOP_WORD;
                    state_reg <= ST_WAIT;
                end
                ST_WAIT: begin
                    // Completion wins over a watchdog expiry seen in the same cycle.
                    if (!bus.pq_busy_i) begin
                        rsp_valid_reg <= 1'b1;
                        rsp_err_reg   <= 1'b0;
                        state_reg     <= ST_RESP;
                    end else if (wd_expire) begin
                        rsp_valid_reg <= 1'b1;
                        rsp_err_reg   <= 1'b1;
                        rsp_data_reg  <= '0;
                        fault_reg     <= 1'b1;
                        state_reg     <= ST_RESP;
                    end
                end
                ST_RESP: begin
                    if (bus.rsp_ready_i) begin
                        rsp_valid_reg <= 1'b0;
                        state_reg     <= ST_IDLE;
                    end
                end
                default: begin
                    state_reg <= ST_IDLE;
                    cmd_reg   <= NOP_WORD;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_pq_host_driver.sv
// Randomized bench for pq_host_driver: a behavioural max-queue emulator drives the queue side,
// and a list-based reference model predicts every response, count and cycle latency.
module tb_pq_host_driver;
    import pq_pkg::*;

    localparam int W       = 65;
    localparam int DEPTH   = 4;
    localparam int TIMEOUT = 12;

    logic clk  = 1'b0;
    logic rstn = 1'b0;
    always #5 clk = ~clk;

    pq_host_driver_if #(.W(W), .DEPTH(DEPTH)) bus ();

    pq_host_driver #(
        .W(W), .DEPTH(DEPTH), .TIMEOUT(TIMEOUT)
    ) dut (
        .system1000     (clk),
        .system1000_rstn(rstn),
        .bus            (bus)
    );

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check_eq(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic int argmax(input logic [W-1:0] q[$]);
        int best = -1;
        foreach (q[i]) if (best < 0 || q[i] > q[best]) best = i;
        return best;
    endfunction

    function automatic logic [W-1:0] rnd_val();
        return {1'($urandom_range(0, 1)), 32'($urandom), 32'($urandom)};
    endfunction

    // ---------------- queue emulator (max-heap behaviour, configurable busy time) -------------
    logic [W-1:0] emu_q[$];
    int           emu_left = 0;
    int           emu_lat  = 0;
    bit           stuck_mode = 1'b0;
    logic [1:0]   emu_pend_op = OP_NOP;
    logic [W-1:0] emu_pend_val = '0;

    task automatic emu_apply();
        int idx;
        if (emu_pend_op == OP_PUSH) emu_q.push_back(emu_pend_val);
        else begin
            idx = argmax(emu_q);
            if (idx >= 0) emu_q.delete(idx);
        end
        idx = argmax(emu_q);
        bus.pq_top_i = (idx >= 0) ? emu_q[idx] : '0;
    endtask

    initial begin
        bus.pq_busy_i = 1'b0;
        bus.pq_top_i  = '0;
        forever begin
            @(negedge clk or negedge rstn);
            if (!rstn) begin
                emu_q.delete();
                emu_left      = 0;
                bus.pq_busy_i = 1'b0;
                bus.pq_top_i  = '0;
            end else begin
                if (emu_left > 0) begin
                    emu_left--;
                    if (emu_left == 0) begin
                        bus.pq_busy_i = 1'b0;
                        emu_apply();
                    end
                end else if (!stuck_mode) begin
                    bus.pq_busy_i = 1'b0;
                end
                if (bus.cmd_o[W+1:W] == OP_PUSH || bus.cmd_o[W+1:W] == OP_POP) begin
                    emu_pend_op  = bus.cmd_o[W+1:W];
                    emu_pend_val = bus.cmd_o[W-1:0];
                    if (stuck_mode) begin
                        bus.pq_busy_i = 1'b1;
                        emu_left      = 0;
                    end else if (emu_lat == 0) begin
                        emu_apply();
                    end else begin
                        bus.pq_busy_i = 1'b1;
                        emu_left      = emu_lat + 1;
                    end
                end
            end
        end
    end

    // ---------------- reference model ----------------
    logic [W-1:0] ref_q[$];
    int           ref_count = 0;
    bit           ref_fault = 1'b0;

    // One request/response transaction; lat = cycles the queue stays busy, hold = response stall.
    task automatic do_req(input bit op, input logic [W-1:0] data, input int lat, input int hold,
                          input bit timeout_case);
        logic [W-1:0] exp_data = '0;
        logic [W+1:0] exp_cmd;
        bit           exp_err  = 1'b0;
        bit           issued;
        bit           stable;
        int           idx;
        int           n;
        int           exp_lat;

        if (!op) begin
            if (ref_count == DEPTH) exp_err = 1'b1;
            else begin
                ref_count++;
                if (!timeout_case) ref_q.push_back(data);
            end
        end else begin
            if (ref_count == 0) exp_err = 1'b1;
            else begin
                ref_count--;
                idx = argmax(ref_q);
                if (idx >= 0) begin
                    exp_data = ref_q[idx];
                    ref_q.delete(idx);
                end
            end
        end
        issued  = !exp_err;
        exp_cmd = !issued ? {OP_NOP, W'(0)} : (op ? {OP_POP, W'(0)} : {OP_PUSH, data});
        if (timeout_case && issued) begin
            exp_err   = 1'b1;
            exp_data  = '0;
            ref_fault = 1'b1;
        end

        emu_lat = lat;
        @(negedge clk);
        bus.req_valid_i = 1'b1;
        bus.req_op_i    = op;
        bus.req_data_i  = data;
        bus.rsp_ready_i = 1'b0;
        n = 0;
        while (!bus.req_ready_o && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (!bus.req_ready_o) begin
            check_eq("accept_wait", 128'(bus.req_ready_o), 128'(1));
            bus.req_valid_i = 1'b0;
            return;
        end
        @(posedge clk);
        @(negedge clk);
        bus.req_valid_i = 1'b0;
        check_eq("cmd_cycle1", 128'(bus.cmd_o), 128'(exp_cmd));
        check_eq("err_rsp_cycle1", 128'(bus.rsp_valid_o), 128'(!issued));

        n = 1;
        if (issued) begin
            @(negedge clk);
            n = 2;
            check_eq("cmd_cycle2_nop", 128'(bus.cmd_o), 128'({OP_NOP, W'(0)}));
            while (!bus.rsp_valid_o && n < TIMEOUT + 10) begin
                @(negedge clk);
                n++;
            end
            exp_lat = timeout_case ? TIMEOUT + 2 : lat + 3;
            check_eq("latency", 128'(n), 128'(exp_lat));
        end

        check_eq("rsp_valid", 128'(bus.rsp_valid_o), 128'(1));
        check_eq("rsp_data", 128'(bus.rsp_data_o), 128'(exp_data));
        check_eq("rsp_err", 128'(bus.rsp_err_o), 128'(exp_err));
        check_eq("count", 128'(bus.count_o), 128'(ref_count));
        check_eq("fault", 128'(bus.fault_o), 128'(ref_fault));

        if (hold > 0) begin
            stable = 1'b1;
            for (int i = 0; i < hold; i++) begin
                @(negedge clk);
                stable &= bus.rsp_valid_o && (bus.rsp_data_o == exp_data) &&
                          (bus.rsp_err_o == exp_err) && !bus.req_ready_o;
            end
            check_eq("hold_stable", 128'(stable), 128'(1));
        end
        bus.rsp_ready_i = 1'b1;
        @(negedge clk);
        check_eq("rsp_done", 128'(bus.rsp_valid_o), 128'(0));
        bus.rsp_ready_i = 1'b0;

        $display("[TB] op=%s data=%0h busy=%0d hold=%0d -> cycles=%0d err=%0b rdata=%0h count=%0d fault=%0b",
                 op ? "pop " : "push", data, lat, hold, n, exp_err, exp_data, ref_count, ref_fault);
    endtask

    // ---------------- main sequence ----------------
    initial begin
        bit           stable;
        bit           op;
        logic [W-1:0] d;
        int           n;

        bus.req_valid_i = 1'b0;
        bus.req_op_i    = 1'b0;
        bus.req_data_i  = '0;
        bus.rsp_ready_i = 1'b0;

        rstn = 1'b0;
        repeat (3) @(negedge clk);
        rstn = 1'b1;
        @(negedge clk);
        check_eq("rst_cmd", 128'(bus.cmd_o), 128'({OP_NOP, W'(0)}));
        check_eq("rst_rsp_valid", 128'(bus.rsp_valid_o), 128'(0));
        check_eq("rst_rsp_data", 128'(bus.rsp_data_o), 128'(0));
        check_eq("rst_rsp_err", 128'(bus.rsp_err_o), 128'(0));
        check_eq("rst_count", 128'(bus.count_o), 128'(0));
        check_eq("rst_fault", 128'(bus.fault_o), 128'(0));
        check_eq("rst_ready", 128'(bus.req_ready_o), 128'(1));

        // push then pop, empty pop, fill to full, overflow, backpressure
        do_req(1'b0, 65'h1_0000_0005, 10, 0, 1'b0);
        do_req(1'b1, '0, 4, 0, 1'b0);
        do_req(1'b1, '0, 0, 0, 1'b0);
        for (int i = 0; i < DEPTH; i++) do_req(1'b0, rnd_val(), $urandom_range(0, TIMEOUT - 1), 0, 1'b0);
        do_req(1'b0, rnd_val(), 2, 0, 1'b0);
        do_req(1'b1, '0, 3, 20, 1'b0);

        for (int i = 0; i < 40; i++) begin
            op = ($urandom_range(0, 99) < 50);
            do_req(op, rnd_val(), $urandom_range(0, TIMEOUT - 1),
                   ($urandom_range(0, 9) == 0) ? 20 : $urandom_range(0, 3), 1'b0);
        end

        // watchdog: queue never leaves busy
        stuck_mode = 1'b1;
        do_req(ref_count == DEPTH, rnd_val(), 0, 0, 1'b1);
        stable = 1'b1;
        repeat (5) begin
            @(negedge clk);
            stable &= bus.fault_o && !bus.req_ready_o;
        end
        check_eq("fault_sticky", 128'(stable), 128'(1));
        stuck_mode = 1'b0;
        repeat (2) @(negedge clk);
        check_eq("ready_after_release", 128'(bus.req_ready_o), 128'(1));
        check_eq("fault_still_set", 128'(bus.fault_o), 128'(1));

        // asynchronous reset while waiting on the queue
        op      = (ref_count == DEPTH);
        emu_lat = 6;
        ref_count = op ? ref_count - 1 : ref_count + 1;
        @(negedge clk);
        bus.req_valid_i = 1'b1;
        bus.req_op_i    = op;
        bus.req_data_i  = rnd_val();
        n = 0;
        while (!bus.req_ready_o && n < 100) begin
            @(negedge clk);
            n++;
        end
        check_eq("rstwait_accept", 128'(bus.req_ready_o), 128'(1));
        @(posedge clk);
        @(negedge clk);
        bus.req_valid_i = 1'b0;
        repeat (2) @(negedge clk);
        check_eq("count_pre_rst", 128'(bus.count_o), 128'(ref_count));
        #2 rstn = 1'b0;
        #1;
        check_eq("midrst_cmd", 128'(bus.cmd_o), 128'({OP_NOP, W'(0)}));
        check_eq("midrst_rsp_valid", 128'(bus.rsp_valid_o), 128'(0));
        check_eq("midrst_rsp_data", 128'(bus.rsp_data_o), 128'(0));
        check_eq("midrst_rsp_err", 128'(bus.rsp_err_o), 128'(0));
        check_eq("midrst_count", 128'(bus.count_o), 128'(0));
        check_eq("midrst_fault", 128'(bus.fault_o), 128'(0));
        check_eq("midrst_ready", 128'(bus.req_ready_o), 128'(1));
        repeat (2) @(negedge clk);
        rstn = 1'b1;
        ref_q.delete();
        ref_count = 0;
        ref_fault = 1'b0;
        @(negedge clk);

        d = rnd_val();
        do_req(1'b0, d, 1, 0, 1'b0);
        do_req(1'b1, '0, 0, 0, 1'b0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL global_time_limit: got no finish expected finish");
        $fatal(1);
    end

endmodule
